// File: rtl/phase_pkg.sv
// Shared phase definitions for the phase sequencer and the control unit.
// The one-hot codes below are the values seen on the fase bus.
package phase_pkg;

  localparam int NUM_PHASES = 5;

  localparam logic [NUM_PHASES-1:0] PH_IDLE = 5'b00000;
  localparam logic [NUM_PHASES-1:0] PH_P1   = 5'b00001;  // fetch
  localparam logic [NUM_PHASES-1:0] PH_P2   = 5'b00010;  // decode
  localparam logic [NUM_PHASES-1:0] PH_P3   = 5'b00100;  // execute
  localparam logic [NUM_PHASES-1:0] PH_P4   = 5'b01000;  // memory
  localparam logic [NUM_PHASES-1:0] PH_P5   = 5'b10000;  // writeback

  // The state encoding is the bus encoding, so fase is the state register.
  typedef enum logic [NUM_PHASES-1:0] {
    ST_IDLE = PH_IDLE,
    ST_P1   = PH_P1,
    ST_P2   = PH_P2,
    ST_P3   = PH_P3,
    ST_P4   = PH_P4,
    ST_P5   = PH_P5
  } phase_e;

endpackage

// File: rtl/phase_generator_if.sv
// Run-control / control-unit side signals of the phase sequencer.
// The master is the sequencer (source of fase); the slave drives run control.
// Optional feature macro: PHASE_STEP_EN adds the single-step request line.
interface phase_generator_if
  import phase_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic                  start;
  logic                  stall;
  logic                  skip_p4;
  logic                  halt;
`ifdef PHASE_STEP_EN
  logic                  step;
`endif
  logic [NUM_PHASES-1:0] fase;
  logic                  busy;
  logic                  done;
  logic [CNT_W-1:0]      instr_cnt;

`ifdef PHASE_STEP_EN
  modport master (
    input  start, stall, skip_p4, halt, step,
    output fase, busy, done, instr_cnt
  );
  modport slave (
    output start, stall, skip_p4, halt, step,
    input  fase, busy, done, instr_cnt
  );
`else
  modport master (
    input  start, stall, skip_p4, halt,
    output fase, busy, done, instr_cnt
  );
  modport slave (
    output start, stall, skip_p4, halt,
    input  fase, busy, done, instr_cnt
  );
`endif

endinterface

// File: rtl/phase_generator.sv
// Multi-cycle phase sequencer: steps each instruction through P1..P5 with
// stall, memory-phase skip, halt-at-boundary and a retired-instruction count.
// Optional feature macro: PHASE_STEP_EN enables single-step mode (step input).
module phase_generator
  import phase_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  phase_generator_if.master pif
);

  phase_e           state_q;
  logic             halt_pend_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stop_req;

  // Conditions that end the run at the next instruction boundary.
`ifdef PHASE_STEP_EN
  assign stop_req = halt_pend_q | pif.halt | pif.step;
`else
  assign stop_req = halt_pend_q | pif.halt;
`endif

  // Phase FSM with sticky halt request, done pulse and retirement counter.
  // NOTE: every register here uses non-blocking assignments so all of them
  // see the same pre-edge values; later assignments in the block override
  // earlier defaults, which the halt latch clear relies on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      halt_pend_q <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      done_q <= 1'b0;

      // A halt seen in any active phase is remembered until IDLE is entered.
      if (state_q != ST_IDLE && pif.halt) begin
        halt_pend_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          // halt in IDLE blocks the start but is not remembered.
          if (pif.start && !pif.halt) begin
            state_q <= ST_P1;
          end
        end
        ST_P1: if (!pif.stall) state_q <= ST_P2;
        ST_P2: if (!pif.stall) state_q <= ST_P3;
        ST_P3: begin
          if (!pif.stall) begin
            state_q <= pif.skip_p4 ? ST_P5 : ST_P4;
          end
        end
        ST_P4: if (!pif.stall) state_q <= ST_P5;
        ST_P5: begin
          if (!pif.stall) begin
            cnt_q  <= cnt_q + 1'b1;
            done_q <= 1'b1;
            if (stop_req) begin
              state_q     <= ST_IDLE;
              halt_pend_q <= 1'b0;
            end else begin
              state_q <= ST_P1;
            end
          end
        end
        default: begin
          // Any non-one-hot encoding recovers to IDLE.
          state_q     <= ST_IDLE;
          halt_pend_q <= 1'b0;
        end
      endcase
    end
  end

  assign pif.fase      = state_q;
  assign pif.busy      = |state_q;
  assign pif.done      = done_q;
  assign pif.instr_cnt = cnt_q;

endmodule
